// File: rtl/h264ncontext_pkg.sv
// h264ncontext_pkg: shared constants, types and address helpers for the
// H.264 CAVLC nC (neighbour total-coefficient) context predictor.
//   MAXMBX      : maximum macroblocks per row (mbx counter range)
//   SLOT_*      : line-memory slot base per component (luma 0-3, Cb 4-5, Cr 6-7)
//   ncount_t    : 5-bit total-coefficient count (0..16)
package h264ncontext_pkg;

  localparam int unsigned MAXMBX  = 128;
  localparam int unsigned MBX_W   = $clog2(MAXMBX);
  localparam int unsigned LM_AW   = MBX_W + 3;
  localparam int unsigned LM_DEPTH = MAXMBX * 8;

  // In-MB array: 16 luma slots {y,x} followed by 8 chroma slots {cr,y,x}.
  localparam int unsigned NBLK  = 24;
  // Left-column store: 4 luma rows followed by 4 chroma rows {cr,y}.
  localparam int unsigned NLEFT = 8;

  localparam logic [2:0] SLOT_LUMA0 = 3'd0;
  localparam logic [2:0] SLOT_CB0   = 3'd4;
  localparam logic [2:0] SLOT_CR0   = 3'd6;

  typedef logic [4:0] ncount_t;

  function automatic logic [4:0] blk_idx(input logic chroma, input logic cr,
                                         input logic [1:0] x, input logic [1:0] y);
    return chroma ? {2'b10, cr, y[0], x[0]} : {1'b0, y, x};
  endfunction

  function automatic logic [2:0] left_idx(input logic chroma, input logic cr,
                                          input logic [1:0] y);
    return chroma ? {1'b1, cr, y[0]} : {1'b0, y};
  endfunction

  function automatic logic [2:0] line_slot(input logic chroma, input logic cr,
                                           input logic [1:0] x);
    return chroma ? ((cr ? SLOT_CR0 : SLOT_CB0) + {2'b00, x[0]})
                  : (SLOT_LUMA0 + {1'b0, x});
  endfunction

endpackage

// File: rtl/h264ncontext_linemem.sv
// h264ncontext_linemem: line memory holding bottom-row counts of the previous
// MB row, addressed {mbx, slot}. 1024 x 5, synchronous write, async read.
//   clk_i    : clock
//   we_i     : write enable
//   waddr_i  : write address {mbx, slot}
//   wdata_i  : write data
//   raddr_i  : read address {mbx, slot}
//   rdata_o  : combinational read data
module h264ncontext_linemem
  import h264ncontext_pkg::*;
(
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [LM_AW-1:0] waddr_i,
  input  logic [4:0]       wdata_i,
  input  logic [LM_AW-1:0] raddr_i,
  output logic [4:0]       rdata_o
);

  logic [4:0] mem_q [LM_DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/h264ncontext.sv
// h264ncontext: predicts nC for the 4x4 block addressed by NX/NY from its
// left and top neighbour total-coefficient counts; NIN is registered.
//   CLK      : clock
//   NEWSLICE : synchronous active-high reset / start of slice
//   NEWLINE  : first MB of a new MB row (clears mbx)
//   NLOAD    : write NOUT as the count of block NX/NY
//   NX, NY   : block address (NX[2]=chroma, NX[1]=Cr for chroma)
//   NV       : neighbour valid, [0]=left, [1]=top
//   NXINC    : advance mbx
//   NOUT     : completed block total-coefficient count
//   NIN      : predicted nC
// Optional: define H264NCONTEXT_CHECK_EN to compile in runtime $warning checks.
module h264ncontext
  import h264ncontext_pkg::*;
(
  input  logic       CLK,
  input  logic       NEWSLICE,
  input  logic       NEWLINE,
  input  logic       NLOAD,
  input  logic [2:0] NX,
  input  logic [2:0] NY,
  input  logic [1:0] NV,
  input  logic       NXINC,
  input  logic [4:0] NOUT,
  output logic [4:0] NIN
);

  ncount_t          blk_q  [NBLK];
  ncount_t          left_q [NLEFT];
  logic [MBX_W-1:0] mbx_q, mbx_d;
  ncount_t          nin_q, nin_d;

  logic       is_chroma, is_cr;
  logic [1:0] bx, by, bmax;
  ncount_t    l_val, t_val, lm_rdata;
  logic [5:0] sum;
  logic       lm_we;
  logic [LM_AW-1:0] lm_addr;

  assign is_chroma = NX[2];
  assign is_cr     = NX[1];
  assign bx        = is_chroma ? {1'b0, NX[0]} : NX[1:0];
  assign by        = is_chroma ? {1'b0, NY[0]} : NY[1:0];
  assign bmax      = is_chroma ? 2'd1 : 2'd3;

  // Read and write share one address: the bottom-row block written is the
  // same column the next row's top-row block reads.
  assign lm_addr = {mbx_q, line_slot(is_chroma, is_cr, bx)};
  assign lm_we   = NLOAD && !NEWSLICE && (by == bmax);

  h264ncontext_linemem u_linemem (
    .clk_i   (CLK),
    .we_i    (lm_we),
    .waddr_i (lm_addr),
    .wdata_i (NOUT),
    .raddr_i (lm_addr),
    .rdata_o (lm_rdata)
  );

  always_comb begin
    l_val = (bx != 2'd0) ? blk_q[blk_idx(is_chroma, is_cr, bx - 2'd1, by)]
                         : left_q[left_idx(is_chroma, is_cr, by)];
    t_val = (by != 2'd0) ? blk_q[blk_idx(is_chroma, is_cr, bx, by - 2'd1)]
                         : lm_rdata;
    sum   = {1'b0, l_val} + {1'b0, t_val} + 6'd1;
    nin_d = '0;
    case (NV)
      2'b11:   nin_d = sum[5:1];
      2'b01:   nin_d = l_val;
      2'b10:   nin_d = t_val;
      default: nin_d = '0;
    endcase
  end

  always_comb begin
    mbx_d = mbx_q;
    if (NEWLINE)    mbx_d = '0;
    else if (NXINC) mbx_d = mbx_q + 1'b1;
  end

  // Right-column and bottom-row loads write through to the left store and
  // line memory so no copy is needed at MB boundaries.
  always_ff @(posedge CLK) begin
    if (NEWSLICE) begin
      for (int unsigned i = 0; i < NBLK; i++)  blk_q[i]  <= '0;
      for (int unsigned i = 0; i < NLEFT; i++) left_q[i] <= '0;
      mbx_q <= '0;
      nin_q <= '0;
    end else begin
      if (NLOAD) begin
        blk_q[blk_idx(is_chroma, is_cr, bx, by)] <= NOUT;
        if (bx == bmax) left_q[left_idx(is_chroma, is_cr, by)] <= NOUT;
      end
      mbx_q <= mbx_d;
      nin_q <= nin_d;
    end
  end

  assign NIN = nin_q;

`ifdef H264NCONTEXT_CHECK_EN
  logic first_row_q;

  always_ff @(posedge CLK) begin
    if (NEWSLICE)     first_row_q <= 1'b1;
    else if (NEWLINE) first_row_q <= 1'b0;
    if (!NEWSLICE) begin
      if (NLOAD && (NOUT > 5'd16))
        $warning("h264ncontext: NOUT=%0d exceeds 16", NOUT);
      if ($isunknown({NX, NY, NV}))
        $warning("h264ncontext: unknown NX/NY/NV");
      if (first_row_q && NV[1])
        $warning("h264ncontext: top neighbour flagged valid on first row");
      if (NXINC && !NEWLINE && (mbx_q == MBX_W'(MAXMBX - 1)))
        $warning("h264ncontext: mbx wraps to 0");
    end
  end
`endif

endmodule

// File: tb/tb_h264ncontext.sv
module tb_h264ncontext;

  logic       CLK = 1'b0;
  logic       NEWSLICE = 1'b0, NEWLINE = 1'b0, NLOAD = 1'b0, NXINC = 1'b0;
  logic [2:0] NX = '0, NY = '0;
  logic [1:0] NV = '0;
  logic [4:0] NOUT = '0;
  logic [4:0] NIN;

  h264ncontext dut (
    .CLK(CLK), .NEWSLICE(NEWSLICE), .NEWLINE(NEWLINE), .NLOAD(NLOAD),
    .NX(NX), .NY(NY), .NV(NV), .NXINC(NXINC), .NOUT(NOUT), .NIN(NIN)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: per-component 2D block grid, per-component left column,
  // and per-MB-column bottom rows of the previous MB row.
  int m_blk  [3][4][4];
  int m_lft  [3][4];
  int m_line [128][3][4];
  bit m_lv   [128][3][4];
  int m_mbx;

  task automatic model_clear();
    foreach (m_blk[c, y, x]) m_blk[c][y][x] = 0;
    foreach (m_lft[c, y])    m_lft[c][y] = 0;
    m_mbx = 0;
  endtask

  task automatic cyc(input bit ns, input bit nl, input bit ld, input bit inc,
                     input bit [2:0] nx, input bit [2:0] ny, input bit [1:0] nv,
                     input int nout, input string tag);
    int c, x, y, xm, ym, l, t, e;
    bit ok;
    @(negedge CLK);
    NEWSLICE = ns; NEWLINE = nl; NLOAD = ld; NXINC = inc;
    NX = nx; NY = ny; NV = nv; NOUT = 5'(nout);
    c  = nx[2] ? (nx[1] ? 2 : 1) : 0;
    x  = nx[2] ? int'(nx[0]) : int'(nx[1:0]);
    y  = nx[2] ? int'(ny[0]) : int'(ny[1:0]);
    xm = nx[2] ? 1 : 3;
    ym = xm;
    ok = 1'b1;
    l  = (x > 0) ? m_blk[c][y][x-1] : m_lft[c][y];
    if (y > 0) t = m_blk[c][y-1][x];
    else begin
      t = m_line[m_mbx][c][x];
      if (nv[1] && !m_lv[m_mbx][c][x]) ok = 1'b0;
    end
    case (nv)
      2'd0: e = 0;
      2'd1: e = l;
      2'd2: e = t;
      default: e = (l + t + 1) / 2;
    endcase
    if (ns) begin e = 0; ok = 1'b1; end
    @(posedge CLK);
    #1;
    if (ok) check_eq(tag, NIN, e);
    if (ns) model_clear();
    else begin
      if (ld) begin
        m_blk[c][y][x] = nout;
        if (x == xm) m_lft[c][y] = nout;
        if (y == ym) begin
          m_line[m_mbx][c][x] = nout;
          m_lv[m_mbx][c][x]   = 1'b1;
        end
      end
      if (nl) m_mbx = 0;
      else if (inc) m_mbx = (m_mbx + 1) % 128;
    end
  endtask

  initial begin
    foreach (m_lv[m, c, x]) begin m_lv[m][c][x] = 1'b0; m_line[m][c][x] = 0; end
    model_clear();

    cyc(1, 0, 0, 0, 3'b000, 3'b000, 2'b00, 0, "reset");
    check_eq("reset_lit", NIN, 0);

    cyc(0, 0, 0, 0, 3'b000, 3'b000, 2'b00, 0, "r029");
    check_eq("r029_lit", NIN, 0);

    cyc(0, 0, 1, 0, 3'b000, 3'b000, 2'b00, 7, "r030_ld");
    cyc(0, 0, 0, 0, 3'b001, 3'b000, 2'b01, 0, "r030");
    check_eq("r030_lit", NIN, 7);

    cyc(0, 0, 1, 0, 3'b000, 3'b001, 2'b00, 5, "r031_ldl");
    cyc(0, 0, 1, 0, 3'b001, 3'b000, 2'b00, 8, "r031_ldt");
    cyc(0, 0, 0, 0, 3'b001, 3'b001, 2'b11, 0, "r031");
    check_eq("r031_lit", NIN, 7);

    cyc(0, 0, 1, 0, 3'b011, 3'b000, 2'b00, 12, "r032_ld");
    cyc(0, 0, 0, 1, 3'b000, 3'b000, 2'b00, 0, "r032_inc");
    cyc(0, 0, 0, 0, 3'b000, 3'b000, 2'b01, 0, "r032");
    check_eq("r032_lit", NIN, 12);

    cyc(0, 1, 0, 0, 3'b000, 3'b000, 2'b00, 0, "r033_nl");
    cyc(0, 0, 0, 1, 3'b000, 3'b000, 2'b00, 0, "r033_i0");
    cyc(0, 0, 0, 1, 3'b000, 3'b000, 2'b00, 0, "r033_i1");
    cyc(0, 0, 1, 0, 3'b001, 3'b011, 2'b00, 16, "r033_ld");
    cyc(0, 1, 0, 0, 3'b000, 3'b000, 2'b00, 0, "r033_nl2");
    cyc(0, 0, 0, 1, 3'b000, 3'b000, 2'b00, 0, "r033_i2");
    cyc(0, 0, 0, 1, 3'b000, 3'b000, 2'b00, 0, "r033_i3");
    cyc(0, 0, 0, 0, 3'b001, 3'b000, 2'b10, 0, "r033");
    check_eq("r033_lit", NIN, 16);

    cyc(0, 0, 1, 0, 3'b000, 3'b000, 2'b00, 9, "r034_ld");
    cyc(1, 0, 0, 0, 3'b000, 3'b000, 2'b00, 0, "r034_ns");
    cyc(0, 0, 0, 0, 3'b001, 3'b000, 2'b01, 0, "r034");
    check_eq("r034_lit", NIN, 0);

    // NEWLINE wins over a coincident NXINC
    cyc(0, 1, 1, 0, 3'b010, 3'b011, 2'b00, 13, "nlpri_ld");
    cyc(0, 0, 0, 1, 3'b000, 3'b000, 2'b00, 0, "nlpri_i0");
    cyc(0, 1, 0, 1, 3'b000, 3'b000, 2'b00, 0, "nlpri_both");
    cyc(0, 0, 0, 0, 3'b010, 3'b000, 2'b10, 0, "nlpri");
    check_eq("nlpri_lit", NIN, 13);

    // NLOAD coincident with NXINC writes at the pre-increment mbx
    cyc(0, 1, 0, 0, 3'b000, 3'b000, 2'b00, 0, "preinc_nl");
    cyc(0, 0, 1, 1, 3'b011, 3'b011, 2'b00, 6, "preinc_ld");
    cyc(0, 1, 0, 0, 3'b000, 3'b000, 2'b00, 0, "preinc_nl2");
    cyc(0, 0, 0, 0, 3'b011, 3'b000, 2'b10, 0, "preinc");
    check_eq("preinc_lit", NIN, 6);

    // mbx wraps 127 -> 0
    cyc(0, 1, 1, 0, 3'b000, 3'b011, 2'b00, 3, "wrap_ld");
    for (int i = 0; i < 128; i++) cyc(0, 0, 0, 1, 3'b000, 3'b000, 2'b00, 0, "wrap_inc");
    cyc(0, 0, 0, 0, 3'b000, 3'b000, 2'b10, 0, "wrap");
    check_eq("wrap_lit", NIN, 3);

    // Chroma: Cr right-bottom block feeds Cr left store and line slot 7
    cyc(0, 1, 1, 0, 3'b111, 3'b001, 2'b00, 10, "cr_ld");
    cyc(0, 0, 0, 0, 3'b110, 3'b000, 2'b00, 0, "cr_chk_top");
    cyc(0, 0, 0, 1, 3'b000, 3'b000, 2'b00, 0, "cr_inc");
    cyc(0, 0, 0, 0, 3'b110, 3'b001, 2'b01, 0, "cr_left");
    check_eq("cr_left_lit", NIN, 10);

    for (int i = 0; i < 3000; i++) begin
      cyc(($urandom % 150) == 0, ($urandom % 40) == 0, ($urandom % 2) == 1,
          ($urandom % 4) == 0, 3'($urandom), 3'($urandom), 2'($urandom),
          int'($urandom_range(0, 16)), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
